// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch controller.
// Drives the PC register (pc_next/pc_ce) from its Q output, requests words
// from instruction memory over req/ack, and presents them to decode through a
// one-entry valid/ready buffer backed by a hold register.
// Optional feature: define FETCH_MISALIGN_EN to turn a misaligned PC into a
// buffered fault entry (if_fault) instead of a memory request.
module fetch_ctrl #(
    parameter logic [31:0] PC_STEP   = 32'd4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        pc_ce,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready
`ifdef FETCH_MISALIGN_EN
    ,
    output logic        if_fault
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e      state_q,      state_d;
    logic        imem_req_q,   imem_req_d;
    logic [31:0] imem_addr_q,  imem_addr_d;
    logic        kill_q,       kill_d;
    logic        if_valid_q,   if_valid_d;
    logic [31:0] if_instr_q,   if_instr_d;
    logic [31:0] if_pc_q,      if_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q,    hold_pc_d;
`ifdef FETCH_MISALIGN_EN
    logic        if_fault_q,   if_fault_d;
`endif

    logic        buf_free;
    logic        pc_mis;
    logic        pc_ce_c;
    logic [31:0] pc_next_c;

`ifdef FETCH_MISALIGN_EN
    assign pc_mis = (pc[1:0] != 2'b00);
`else
    assign pc_mis = 1'b0;
`endif

    // Next-state, buffer and PC-update decisions; redirect outranks everything.
    always_comb begin
        state_d      = state_q;
        imem_req_d   = imem_req_q;
        imem_addr_d  = imem_addr_q;
        kill_d       = kill_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
`ifdef FETCH_MISALIGN_EN
        if_fault_d   = if_fault_q;
`endif
        pc_ce_c      = 1'b0;
        pc_next_c    = pc;

        buf_free   = !if_valid_q || id_ready;
        // A transfer empties the buffer unless a load below refills it.
        if_valid_d = if_valid_q && !id_ready;

        unique case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    pc_ce_c   = 1'b1;
                    pc_next_c = redirect_target;
                end else if (buf_free) begin
                    if (pc_mis) begin
                        // Fault entry replaces the request; PC stays frozen.
                        if_valid_d = 1'b1;
                        if_instr_d = NOP_INSTR;
                        if_pc_d    = pc;
`ifdef FETCH_MISALIGN_EN
                        if_fault_d = 1'b1;
`endif
                    end else begin
                        imem_req_d  = 1'b1;
                        imem_addr_d = pc;
                        state_d     = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (redirect) begin
                    pc_ce_c   = 1'b1;
                    pc_next_c = redirect_target;
                    if (imem_ack) begin
                        imem_req_d = 1'b0;
                        kill_d     = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        // Request cannot be withdrawn; drop its reply later.
                        kill_d = 1'b1;
                    end
                end else if (imem_ack) begin
                    imem_req_d = 1'b0;
                    kill_d     = 1'b0;
                    state_d    = ST_IDLE;
                    if (!kill_q) begin
                        pc_ce_c   = 1'b1;
                        pc_next_c = imem_addr_q + PC_STEP;
                        if (buf_free) begin
                            if_valid_d = 1'b1;
                            if_instr_d = imem_rdata;
                            if_pc_d    = imem_addr_q;
`ifdef FETCH_MISALIGN_EN
                            if_fault_d = 1'b0;
`endif
                        end else begin
                            hold_instr_d = imem_rdata;
                            hold_pc_d    = imem_addr_q;
                            state_d      = ST_HOLD;
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    pc_ce_c   = 1'b1;
                    pc_next_c = redirect_target;
                    state_d   = ST_IDLE;
                end else if (buf_free) begin
                    if_valid_d = 1'b1;
                    if_instr_d = hold_instr_q;
                    if_pc_d    = hold_pc_q;
`ifdef FETCH_MISALIGN_EN
                    if_fault_d = 1'b0;
`endif
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                imem_req_d = 1'b0;
                kill_d     = 1'b0;
            end
        endcase

        // Any redirect flushes the decode buffer (the hold is dropped via IDLE).
        if (redirect) begin
            if_valid_d = 1'b0;
        end

        // An empty buffer always presents the NOP and no fault.
        if (!if_valid_d) begin
            if_instr_d = NOP_INSTR;
`ifdef FETCH_MISALIGN_EN
            if_fault_d = 1'b0;
`endif
        end
    end

    // State and registered-output flops, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= '0;
            kill_q       <= 1'b0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= NOP_INSTR;
            if_pc_q      <= '0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
`ifdef FETCH_MISALIGN_EN
            if_fault_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            imem_req_q   <= imem_req_d;
            imem_addr_q  <= imem_addr_d;
            kill_q       <= kill_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
`ifdef FETCH_MISALIGN_EN
            if_fault_q   <= if_fault_d;
`endif
        end
    end

    assign pc_ce     = pc_ce_c && !rst;
    assign pc_next   = pc_next_c;
    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
`ifdef FETCH_MISALIGN_EN
    assign if_fault  = if_fault_q;
`endif

endmodule
